// File: rtl/mat_switch_port_pkg.sv
// +----------------------------------------------------------------------------+
// | mat_switch_port_pkg: shared types and helpers for the switch port.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mat_switch_port_pkg;
  localparam int LANE_BITS = 32;

  // One shortreal lane carried as its raw IEEE-754 bit pattern.
  typedef logic [LANE_BITS-1:0] lane_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } mat_recv_state_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {31'd0, inc};
    return sum[32] ? '1 : sum[31:0];
  endfunction
endpackage

`default_nettype wire

// File: rtl/mat_switch_port_if.sv
// +----------------------------------------------------------------------------+
// | mat_switch_port_if: core-side and switch-side signals of the switch port. |
// | Optional MAT_SWITCH_PORT_STATS_EN adds statistics. Rev 1.0                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mat_switch_port_if #(
  parameter int SWITCH_WIDTH     = 16,
  parameter int SWITCH_CORE_SIZE = 4
);
  import mat_switch_port_pkg::*;
  localparam int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE);

  logic                             send_valid;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx;
  lane_t [SWITCH_WIDTH-1:0]         send_data;
  logic                             send_full;
  logic                             recv_req_valid;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] recv_req_core_idx;
  logic                             recv_busy;
  logic                             recv_pop;
  logic                             recv_empty;
  lane_t [SWITCH_WIDTH-1:0]         recv_data;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] recv_data_core_idx;
  logic                             idle;
  logic                             switch_send_ready;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx;
  lane_t [SWITCH_WIDTH-1:0]         switch_send_data;
  logic                             switch_send_ok;
  logic                             switch_recv_request;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx;
  logic                             switch_recv_ready;
  lane_t [SWITCH_WIDTH-1:0]         switch_recv_data;
`ifdef MAT_SWITCH_PORT_STATS_EN
  logic                             stat_clear;
  logic [31:0]                      stat_send_count;
  logic [31:0]                      stat_recv_count;
  logic [31:0]                      stat_stall_cycles;
`endif

  modport slave (
`ifdef MAT_SWITCH_PORT_STATS_EN
    input  stat_clear,
    output stat_send_count, stat_recv_count, stat_stall_cycles,
`endif
    input  send_valid, send_core_idx, send_data, recv_req_valid, recv_req_core_idx,
           recv_pop, switch_send_ok, switch_recv_ready, switch_recv_data,
    output send_full, recv_busy, recv_empty, recv_data, recv_data_core_idx, idle,
           switch_send_ready, switch_send_core_idx, switch_send_data,
           switch_recv_request, switch_recv_core_idx
  );

  modport master (
`ifdef MAT_SWITCH_PORT_STATS_EN
    output stat_clear,
    input  stat_send_count, stat_recv_count, stat_stall_cycles,
`endif
    output send_valid, send_core_idx, send_data, recv_req_valid, recv_req_core_idx,
           recv_pop, switch_send_ok, switch_recv_ready, switch_recv_data,
    input  send_full, recv_busy, recv_empty, recv_data, recv_data_core_idx, idle,
           switch_send_ready, switch_send_core_idx, switch_send_data,
           switch_recv_request, switch_recv_core_idx
  );
endinterface

`default_nettype wire

// File: rtl/mat_switch_port_fifo.sv
// +----------------------------------------------------------------------------+
// | mat_switch_port_fifo: power-of-two packet queue of {payload, core index}. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mat_switch_port_fifo
  import mat_switch_port_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LANES  = 16,
  parameter int IDX_W  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              push,
  input  wire lane_t [LANES-1:0] push_data,
  input  wire logic [IDX_W-1:0]  push_idx,
  input  wire logic              pop,
  output lane_t [LANES-1:0]      head_data,
  output logic [IDX_W-1:0]       head_idx,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count
);
  lane_t [LANES-1:0]  r_mem_data [DEPTH];
  logic [IDX_W-1:0]   r_mem_idx  [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // Full is taken from the registered count, so a push while full is
  // refused even when a pop frees a slot on the same edge.
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head_data = r_mem_data[r_rd_ptr];
  assign head_idx  = empty ? '0 : r_mem_idx[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem_data[r_wr_ptr] <= push_data;
      r_mem_idx[r_wr_ptr]  <= push_idx;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mat_switch_port.sv
// +----------------------------------------------------------------------------+
// | mat_switch_port: send/receive queues between a core and the switch.      |
// | Optional MAT_SWITCH_PORT_STATS_EN adds statistics counters. Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module mat_switch_port
  import mat_switch_port_pkg::*;
#(
  parameter int SWITCH_WIDTH     = 16,
  parameter int SWITCH_CORE_SIZE = 4,
  parameter int SEND_DEPTH       = 4,
  parameter int RECV_DEPTH       = 4
) (
  input wire logic       clock,
  input wire logic       reset,
  mat_switch_port_if.slave port
);
  localparam int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE);
  localparam int SEND_CNT_W = $clog2(SEND_DEPTH) + 1;
  localparam int RECV_CNT_W = $clog2(RECV_DEPTH) + 1;

  mat_recv_state_t                  r_state;
  mat_recv_state_t                  w_state_next;
  logic [SWITCH_CORE_ADDR_SIZE-1:0] r_latched_idx;
  logic                             w_send_empty;
  logic                             w_recv_full;
  logic                             w_recv_write;
  logic                             w_recv_accept;
  logic [SEND_CNT_W-1:0]            w_send_count;
  logic [RECV_CNT_W-1:0]            w_recv_count;

  assign w_recv_write  = (r_state == R_WAIT) && port.switch_recv_ready;
  assign w_recv_accept = (r_state == R_IDLE) && port.recv_req_valid && !w_recv_full;

  mat_switch_port_fifo #(.DEPTH(SEND_DEPTH), .LANES(SWITCH_WIDTH), .IDX_W(SWITCH_CORE_ADDR_SIZE)) u_send_fifo (
    .clock(clock), .reset(reset),
    .push(port.send_valid), .push_data(port.send_data), .push_idx(port.send_core_idx),
    .pop(port.switch_send_ok),
    .head_data(port.switch_send_data), .head_idx(port.switch_send_core_idx),
    .full(port.send_full), .empty(w_send_empty), .count(w_send_count)
  );

  mat_switch_port_fifo #(.DEPTH(RECV_DEPTH), .LANES(SWITCH_WIDTH), .IDX_W(SWITCH_CORE_ADDR_SIZE)) u_recv_fifo (
    .clock(clock), .reset(reset),
    .push(w_recv_write), .push_data(port.switch_recv_data), .push_idx(r_latched_idx),
    .pop(port.recv_pop),
    .head_data(port.recv_data), .head_idx(port.recv_data_core_idx),
    .full(w_recv_full), .empty(port.recv_empty), .count(w_recv_count)
  );

  assign port.switch_send_ready = !w_send_empty;
  assign port.recv_busy         = (r_state != R_IDLE) || w_recv_full;
  assign port.idle              = (w_send_count == '0) && (w_recv_count == '0) && (r_state == R_IDLE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (reset)              r_latched_idx <= '0;
    else if (w_recv_accept) r_latched_idx <= port.recv_req_core_idx;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      R_IDLE:  if (w_recv_accept) w_state_next = R_WAIT;
      R_WAIT:  if (port.switch_recv_ready) w_state_next = R_IDLE;
      default: w_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    port.switch_recv_request  = 1'b0;
    port.switch_recv_core_idx = '0;
    if (r_state == R_WAIT) begin
      port.switch_recv_request  = 1'b1;
      port.switch_recv_core_idx = r_latched_idx;
    end
  end

`ifdef MAT_SWITCH_PORT_STATS_EN
  logic [31:0] r_stat_send;
  logic [31:0] r_stat_recv;
  logic [31:0] r_stat_stall;
  logic        w_send_pop;
  logic        w_send_stall;
  logic        w_recv_stall;

  assign w_send_pop   = port.switch_send_ready && port.switch_send_ok;
  assign w_send_stall = port.switch_send_ready && !port.switch_send_ok;
  assign w_recv_stall = (r_state == R_WAIT) && !port.switch_recv_ready;

  // A cycle stalled on both sides contributes two to the stall total.
  always_ff @(posedge clock) begin
    if (reset || port.stat_clear) begin
      r_stat_send  <= '0;
      r_stat_recv  <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_send  <= sat_add(r_stat_send, {1'b0, w_send_pop});
      r_stat_recv  <= sat_add(r_stat_recv, {1'b0, w_recv_write});
      r_stat_stall <= sat_add(r_stat_stall, {1'b0, w_send_stall} + {1'b0, w_recv_stall});
    end
  end

  assign port.stat_send_count   = r_stat_send;
  assign port.stat_recv_count   = r_stat_recv;
  assign port.stat_stall_cycles = r_stat_stall;
`endif
endmodule

`default_nettype wire

// File: tb/tb_mat_switch_port.sv
// +----------------------------------------------------------------------------+
// | tb_mat_switch_port: directed vector bench for mat_switch_port.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mat_switch_port;
  import mat_switch_port_pkg::*;

  typedef logic [15:0][31:0] pkt_t;

  typedef struct {
    logic       sv;
    logic [1:0] sidx;
    logic       ok;
    logic       exp_full;
    logic       exp_ready;
    logic [1:0] exp_head;
    logic       exp_idle;
    int         exp_salt;
  } vec_t;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   hi_cycles;
  vec_t tbl [18];

  mat_switch_port_if #(.SWITCH_WIDTH(16), .SWITCH_CORE_SIZE(4)) bus ();

  mat_switch_port #(
    .SWITCH_WIDTH(16), .SWITCH_CORE_SIZE(4), .SEND_DEPTH(4), .RECV_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .port (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic pkt_t make_pkt(input logic [1:0] idx, input int salt);
    pkt_t p;
    for (int i = 0; i < 16; i++)
      p[i] = 32'h1000_0000 + (32'(salt) << 16) + (32'(idx) << 8) + 32'(i);
    return p;
  endfunction

  // IEEE-754 single encoding of a small positive integer.
  function automatic logic [31:0] int_to_f32(input int n);
    int e;
    e = $clog2(n + 1) - 1;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input pkt_t act, input pkt_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    pkt_t fpkt;
    errors = 0;
    checks = 0;

    tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0};
    tbl[1]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0};
    tbl[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 0};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 0};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 10};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 10};
    tbl[12] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 10};
    tbl[13] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 10};
    tbl[14] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 11};
    tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 12};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 13};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 0};

    bus.send_valid        = 1'b0;
    bus.send_core_idx     = '0;
    bus.send_data         = '0;
    bus.recv_req_valid    = 1'b0;
    bus.recv_req_core_idx = '0;
    bus.recv_pop          = 1'b0;
    bus.switch_send_ok    = 1'b0;
    bus.switch_recv_ready = 1'b0;
    bus.switch_recv_data  = '0;
`ifdef MAT_SWITCH_PORT_STATS_EN
    bus.stat_clear        = 1'b0;
`endif

    reset = 1'b1;
    tick();
    tick();
    chk("rst_send_full", bus.send_full, 0);
    chk("rst_recv_busy", bus.recv_busy, 0);
    chk("rst_recv_empty", bus.recv_empty, 1);
    chk("rst_idle", bus.idle, 1);
    chk("rst_send_ready", bus.switch_send_ready, 0);
    chk("rst_recv_request", bus.switch_recv_request, 0);
    chk("rst_send_idx", bus.switch_send_core_idx, 0);
    chk("rst_recv_core_idx", bus.switch_recv_core_idx, 0);
    chk("rst_recv_data_idx", bus.recv_data_core_idx, 0);
    reset = 1'b0;

    // Send queue: fill, drop on full, drain in order, push rejected while full with pop.
    for (int i = 0; i < 18; i++) begin
      bus.send_valid     = tbl[i].sv;
      bus.send_core_idx  = tbl[i].sidx;
      bus.send_data      = make_pkt(tbl[i].sidx, i);
      bus.switch_send_ok = tbl[i].ok;
      tick();
      chk($sformatf("v%0d_send_full", i), bus.send_full, tbl[i].exp_full);
      chk($sformatf("v%0d_send_ready", i), bus.switch_send_ready, tbl[i].exp_ready);
      chk($sformatf("v%0d_send_idx", i), bus.switch_send_core_idx, tbl[i].exp_head);
      chk($sformatf("v%0d_idle", i), bus.idle, tbl[i].exp_idle);
      if (tbl[i].exp_ready)
        chk_pkt($sformatf("v%0d_send_data", i), bus.switch_send_data,
                make_pkt(tbl[i].exp_head, tbl[i].exp_salt));
    end
    bus.send_valid     = 1'b0;
    bus.switch_send_ok = 1'b0;

    // switch_recv_ready while idle must not write the receive queue.
    bus.switch_recv_ready = 1'b1;
    bus.switch_recv_data  = make_pkt(2'd3, 99);
    tick();
    bus.switch_recv_ready = 1'b0;
    chk("idle_ready_ignored", bus.recv_empty, 1);

    // Request core 2; the switch answers three cycles later with 1.0..16.0.
    for (int i = 0; i < 16; i++) fpkt[i] = int_to_f32(i + 1);
    bus.recv_req_valid    = 1'b1;
    bus.recv_req_core_idx = 2'd2;
    tick();
    bus.recv_req_valid = 1'b0;
    chk("req_core_idx", bus.switch_recv_core_idx, 2);
    chk("req_busy", bus.recv_busy, 1);
    hi_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.switch_recv_request) hi_cycles++;
      bus.switch_recv_ready = (c == 2);
      bus.switch_recv_data  = fpkt;
      tick();
    end
    bus.switch_recv_ready = 1'b0;
    chk("req_high_cycles", hi_cycles, 3);
    chk("recv_not_empty", bus.recv_empty, 0);
    chk("recv_lane5", bus.recv_data[5], 32'h40C0_0000);
    chk("recv_data_idx", bus.recv_data_core_idx, 2);
    bus.recv_pop = 1'b1;
    tick();
    bus.recv_pop = 1'b0;
    chk("recv_pop_empty", bus.recv_empty, 1);
    chk("recv_pop_idle", bus.idle, 1);

    // Fill receive queue with cores 0..3, then a request must wait for a pop.
    for (int k = 0; k < 4; k++) begin
      bus.recv_req_valid    = 1'b1;
      bus.recv_req_core_idx = 2'(k);
      tick();
      bus.recv_req_valid    = 1'b0;
      bus.switch_recv_ready = 1'b1;
      bus.switch_recv_data  = make_pkt(2'(k), 50);
      tick();
      bus.switch_recv_ready = 1'b0;
    end
    chk("full_busy", bus.recv_busy, 1);
    bus.recv_req_valid    = 1'b1;
    bus.recv_req_core_idx = 2'd1;
    tick();
    chk("full_no_request", bus.switch_recv_request, 0);
    bus.recv_pop = 1'b1;
    tick();
    bus.recv_pop = 1'b0;
    chk("pop_no_request_yet", bus.switch_recv_request, 0);
    chk("pop_busy_clear", bus.recv_busy, 0);
    chk("pop_head_idx", bus.recv_data_core_idx, 1);
    tick();
    bus.recv_req_valid = 1'b0;
    chk("accept_after_pop", bus.switch_recv_request, 1);
    chk("accept_core_idx", bus.switch_recv_core_idx, 1);

    // Bring count to 2, then write and pop on the same edge.
    bus.recv_pop = 1'b1;
    tick();
    chk("cnt2_head_idx", bus.recv_data_core_idx, 2);
    bus.switch_recv_ready = 1'b1;
    bus.switch_recv_data  = make_pkt(2'd1, 77);
    tick();
    bus.switch_recv_ready = 1'b0;
    chk("wp_head_idx", bus.recv_data_core_idx, 3);
    chk_pkt("wp_head_data", bus.recv_data, make_pkt(2'd3, 50));
    chk("wp_request_done", bus.switch_recv_request, 0);
    tick();
    chk("wp_new_head_idx", bus.recv_data_core_idx, 1);
    chk_pkt("wp_new_head_data", bus.recv_data, make_pkt(2'd1, 77));
    tick();
    chk("wp_drained", bus.recv_empty, 1);
    tick();
    bus.recv_pop = 1'b0;
    chk("pop_empty_ignored", bus.recv_empty, 1);
    chk("pop_empty_idle", bus.idle, 1);

    // Reset in the middle of a receive handshake with two sends pending.
    bus.send_valid    = 1'b1;
    bus.send_core_idx = 2'd1;
    bus.send_data     = make_pkt(2'd1, 30);
    tick();
    bus.send_core_idx = 2'd2;
    tick();
    bus.send_valid        = 1'b0;
    bus.recv_req_valid    = 1'b1;
    bus.recv_req_core_idx = 2'd3;
    tick();
    bus.recv_req_valid = 1'b0;
    chk("pre_rst_request", bus.switch_recv_request, 1);
    reset                 = 1'b1;
    bus.switch_recv_ready = 1'b1;
    bus.switch_send_ok    = 1'b1;
    tick();
    chk("mid_rst_idle", bus.idle, 1);
    chk("mid_rst_send_ready", bus.switch_send_ready, 0);
    chk("mid_rst_request", bus.switch_recv_request, 0);
    chk("mid_rst_recv_empty", bus.recv_empty, 1);
    chk("mid_rst_busy", bus.recv_busy, 0);
    reset                 = 1'b0;
    bus.switch_recv_ready = 1'b0;
    bus.switch_send_ok    = 1'b0;
    tick();
    chk("post_rst_idle", bus.idle, 1);
    chk("post_rst_recv_empty", bus.recv_empty, 1);

`ifdef MAT_SWITCH_PORT_STATS_EN
    bus.send_valid    = 1'b1;
    bus.send_core_idx = 2'd0;
    tick();
    bus.send_core_idx = 2'd1;
    tick();
    bus.send_valid = 1'b0;
    tick();
    tick();
    bus.switch_send_ok = 1'b1;
    tick();
    tick();
    bus.switch_send_ok = 1'b0;
    chk("stat_stall", bus.stat_stall_cycles, 3);
    chk("stat_send", bus.stat_send_count, 2);
    chk("stat_recv", bus.stat_recv_count, 0);
    bus.stat_clear = 1'b1;
    tick();
    bus.stat_clear = 1'b0;
    chk("stat_clr_stall", bus.stat_stall_cycles, 0);
    chk("stat_clr_send", bus.stat_send_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
